// File: rtl/cv_bus_pkg.sv
// ----------------------------------------------------------------------------
// cv_bus_pkg
// Shared definitions for the 40-bit split-bus RAM responder:
//   - bus field widths (address, data, command)
//   - command encoding: write bit position and the RAM command class
//   - responder FSM state type
//   - fill value returned for an invalid command
// No ports (package).
// ----------------------------------------------------------------------------
package cv_bus_pkg;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 8;
    localparam int CMD_W     = 3;
    localparam int CNT_W     = 4;
    localparam int MEM_DEPTH = 32;

    localparam int               CMD_WR_BIT    = 2;
    localparam logic [1:0]       CMD_CLASS_RAM = 2'b01;
    localparam logic [DATA_W-1:0] RD_FILL      = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } rsp_state_e;

    // A command addresses this RAM only when its class field is the RAM class.
    function automatic logic is_ram_cmd(input logic [CMD_W-1:0] cmd);
        return (cmd[1:0] == CMD_CLASS_RAM);
    endfunction

endpackage

// File: rtl/cv_sram_32x8.sv
// ----------------------------------------------------------------------------
// cv_sram_32x8
// 32 x 8 register-file RAM: synchronous write port, combinational read port.
// Every byte is cleared by the asynchronous active-low reset.
// Ports:
//   i_clk     in   clock, rising edge
//   i_rst_n   in   asynchronous active-low reset (clears all bytes)
//   i_we      in   write enable
//   i_waddr   in   write address
//   i_wdata   in   write data
//   i_raddr   in   read address
//   o_rdata   out  read data (combinational from i_raddr)
// ----------------------------------------------------------------------------
module cv_sram_32x8
    import cv_bus_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cv_sram_rsp_32x8.sv
// ----------------------------------------------------------------------------
// cv_sram_rsp_32x8
// Target-side responder on the S_* split bus for a 32 x 8 RAM. Accepts one
// request at a time, waits WAIT_CYCLES cycles, then performs the byte write
// or read and raises S_EX_ACK for exactly one cycle.
//
// Parameter:
//   WAIT_CYCLES  wait states between accept and acknowledge (0..15)
// Ports:
//   CLK       in   system clock, rising edge
//   RST_N     in   asynchronous active-low reset
//   S_EX_REQ  in   request, held by the initiator until ACK
//   S_ADDR    in   byte address
//   S_CMD     in   command: [2] 1=write/0=read, [1:0] must be RAM class
//   S_D_WR    in   write data
//   S_EX_ACK  out  single-cycle acknowledge
//   S_D_RD    out  read data / write echo / FF for invalid command
//   ERR_CNT   out  saturating invalid-command count (only when the
//                  CV_SRAM_RSP_ERRCNT_EN macro is defined)
// ----------------------------------------------------------------------------
module cv_sram_rsp_32x8
    import cv_bus_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
)
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              S_EX_REQ,
    input  logic [ADDR_W-1:0] S_ADDR,
    input  logic [CMD_W-1:0]  S_CMD,
    input  logic [DATA_W-1:0] S_D_WR,
    output logic              S_EX_ACK,
    output logic [DATA_W-1:0] S_D_RD
`ifdef CV_SRAM_RSP_ERRCNT_EN
    ,
    output logic [7:0]        ERR_CNT
`endif
);

    localparam bit NO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    rsp_state_e        r_state;
    rsp_state_e        w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [CMD_W-1:0]  r_cmd;
    logic [DATA_W-1:0] r_dwr;
    logic [DATA_W-1:0] r_d_rd;

    logic              w_accept;
    logic              w_enter_ack;
    logic [ADDR_W-1:0] w_cur_addr;
    logic [CMD_W-1:0]  w_cur_cmd;
    logic [DATA_W-1:0] w_cur_dwr;
    logic              w_valid;
    logic              w_we;
    logic [DATA_W-1:0] w_mem_rd;

    assign w_accept = (r_state == IDLE) && S_EX_REQ;

    // The ACK-entry edge is either a zero-wait accept straight from IDLE or
    // the last wait state with the request still held.
    assign w_enter_ack = (w_accept && NO_WAIT) ||
                         ((r_state == WAIT) && S_EX_REQ && (r_cnt == '0));

    // In the zero-wait case the effect happens on the accept edge itself,
    // before the latch holds anything, so the live bus fields are used there.
    assign w_cur_addr = (r_state == IDLE) ? S_ADDR : r_addr;
    assign w_cur_cmd  = (r_state == IDLE) ? S_CMD  : r_cmd;
    assign w_cur_dwr  = (r_state == IDLE) ? S_D_WR : r_dwr;

    assign w_valid = is_ram_cmd(w_cur_cmd);
    assign w_we    = w_enter_ack && w_valid && w_cur_cmd[CMD_WR_BIT];

    cv_sram_32x8 u_mem (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_we    (w_we),
        .i_waddr (w_cur_addr),
        .i_wdata (w_cur_dwr),
        .i_raddr (w_cur_addr),
        .o_rdata (w_mem_rd)
    );

    // FSM state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state; a dropped request during WAIT aborts without effect.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (S_EX_REQ) begin
                    w_next_state = NO_WAIT ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (!S_EX_REQ) begin
                    w_next_state = IDLE;
                end else if (r_cnt == '0) begin
                    w_next_state = ACK;
                end
            end
            ACK:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        S_EX_ACK = (r_state == ACK);
        S_D_RD   = r_d_rd;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= CNT_LOAD;
        end else if ((r_state == WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_addr <= '0;
            r_cmd  <= '0;
            r_dwr  <= '0;
        end else if (w_accept) begin
            r_addr <= S_ADDR;
            r_cmd  <= S_CMD;
            r_dwr  <= S_D_WR;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_d_rd <= '0;
        end else if (w_enter_ack) begin
            if (!w_valid) begin
                r_d_rd <= RD_FILL;
            end else if (w_cur_cmd[CMD_WR_BIT]) begin
                r_d_rd <= w_cur_dwr;
            end else begin
                r_d_rd <= w_mem_rd;
            end
        end
    end

`ifdef CV_SRAM_RSP_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_err_cnt <= '0;
        end else if (w_enter_ack && !w_valid && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign ERR_CNT = r_err_cnt;
`endif

endmodule

// File: tb/tb_cv_sram_rsp_32x8.sv
module tb_cv_sram_rsp_32x8;

    localparam int NI = 3;
    localparam int WC [NI] = '{2, 4, 0};

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       req   [NI];
    logic [4:0] addr  [NI];
    logic [2:0] cmd   [NI];
    logic [7:0] wdat  [NI];
    logic       ack_o [NI];
    logic [7:0] rd_o  [NI];
`ifdef CV_SRAM_RSP_ERRCNT_EN
    logic [7:0] err_o [NI];
`endif

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        cv_sram_rsp_32x8 #(.WAIT_CYCLES(WC[g])) u_dut (
            .CLK      (clk),
            .RST_N    (rst_n),
            .S_EX_REQ (req[g]),
            .S_ADDR   (addr[g]),
            .S_CMD    (cmd[g]),
            .S_D_WR   (wdat[g]),
            .S_EX_ACK (ack_o[g]),
            .S_D_RD   (rd_o[g])
`ifdef CV_SRAM_RSP_ERRCNT_EN
            ,
            .ERR_CNT  (err_o[g])
`endif
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level reference: each instance is either free, holding a
    // request with a known completion edge (accept edge + WAIT_CYCLES), or
    // showing its one ACK cycle.
    // ------------------------------------------------------------------
    bit         m_busy [NI];
    bit         m_ack  [NI];
    int         m_due  [NI];
    logic [4:0] m_a    [NI];
    logic [2:0] m_c    [NI];
    logic [7:0] m_d    [NI];
    logic [7:0] m_rd   [NI];
    int         m_err  [NI];
    logic [7:0] m_mem  [NI][32];
    int         cyc;

    task automatic model_clear();
        cyc = 0;
        for (int g = 0; g < NI; g++) begin
            m_busy[g] = 0; m_ack[g] = 0; m_due[g] = 0; m_rd[g] = 8'h00; m_err[g] = 0;
            for (int i = 0; i < 32; i++) m_mem[g][i] = 8'h00;
        end
    endtask

    task automatic model_complete(input int g);
        if (m_c[g][1:0] != 2'b01) begin
            m_rd[g] = 8'hFF;
            if (m_err[g] < 255) m_err[g]++;
        end else if (m_c[g][2]) begin
            m_mem[g][m_a[g]] = m_d[g];
            m_rd[g] = m_d[g];
        end else begin
            m_rd[g] = m_mem[g][m_a[g]];
        end
        m_ack[g] = 1;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_clear();
            end else begin
                for (int g = 0; g < NI; g++) begin
                    if (m_ack[g]) begin
                        m_ack[g] = 0;
                    end else if (!m_busy[g]) begin
                        if (req[g]) begin
                            m_a[g] = addr[g]; m_c[g] = cmd[g]; m_d[g] = wdat[g];
                            if (WC[g] == 0) model_complete(g);
                            else begin m_busy[g] = 1; m_due[g] = cyc + WC[g]; end
                        end
                    end else if (!req[g]) begin
                        m_busy[g] = 0;
                    end else if (cyc == m_due[g]) begin
                        m_busy[g] = 0;
                        model_complete(g);
                    end
                end
                cyc++;
            end
        end
    end

    // Every-cycle comparison against the reference
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && chk_en) begin
                for (int g = 0; g < NI; g++) begin
                    chk($sformatf("ack[%0d]", g), 32'(ack_o[g]), 32'(m_ack[g]));
                    chk($sformatf("rd[%0d]", g), 32'(rd_o[g]), 32'(m_rd[g]));
`ifdef CV_SRAM_RSP_ERRCNT_EN
                    chk($sformatf("err[%0d]", g), 32'(err_o[g]), 32'(m_err[g]));
`endif
                end
            end
        end
    end

    // One request; lat counts falling edges from driving REQ to seeing ACK.
    task automatic xact(input int g, input logic [4:0] a, input logic [2:0] c,
                        input logic [7:0] d, input int drop, input bit keep,
                        output logic [7:0] rd, output int lat, output bit acked);
        @(negedge clk);
        req[g] = 1'b1; addr[g] = a; cmd[g] = c; wdat[g] = d;
        lat = 0; acked = 0; rd = 8'h00;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (ack_o[g]) begin
                acked = 1; rd = rd_o[g];
                break;
            end
            if (drop > 0 && lat == drop) req[g] = 1'b0;
            if (drop > 0 && lat >= WC[g] + 3) break;
        end
        if (!keep) req[g] = 1'b0;
    endtask

    logic [7:0] rd;
    int         lat;
    bit         acked;
    logic [2:0] rc;
    int         dp;

    initial begin
        for (int g = 0; g < NI; g++) begin
            req[g] = 0; addr[g] = 0; cmd[g] = 0; wdat[g] = 0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            chk("rst_ack", 32'(ack_o[g]), 32'd0);
            chk("rst_rd", 32'(rd_o[g]), 32'h00);
        end
        #3 rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        // Fresh RAM reads zero
        xact(0, 5'h07, 3'b001, 8'h00, 0, 0, rd, lat, acked);
        chk("fresh_rd", 32'(rd), 32'h00);

        // Write then read back, WAIT_CYCLES=2
        xact(0, 5'h0A, 3'b101, 8'h5C, 0, 0, rd, lat, acked);
        chk("wr_acked", 32'(acked), 32'd1);
        chk("wr_echo", 32'(rd), 32'h5C);
        chk("wr_lat", 32'(lat), 32'd3);
        xact(0, 5'h0A, 3'b001, 8'h00, 0, 0, rd, lat, acked);
        chk("rd_0A", 32'(rd), 32'h5C);
        chk("rd_lat", 32'(lat), 32'd3);
        xact(0, 5'h0B, 3'b001, 8'h00, 0, 0, rd, lat, acked);
        chk("rd_0B", 32'(rd), 32'h00);

        // Invalid command: acknowledged, FF returned, no write
        xact(0, 5'h03, 3'b110, 8'h77, 0, 0, rd, lat, acked);
        chk("inv_acked", 32'(acked), 32'd1);
        chk("inv_rd", 32'(rd), 32'hFF);
`ifdef CV_SRAM_RSP_ERRCNT_EN
        chk("inv_errcnt", 32'(err_o[0]), 32'd1);
`endif
        xact(0, 5'h03, 3'b001, 8'h00, 0, 0, rd, lat, acked);
        chk("rd_03", 32'(rd), 32'h00);

        // Abort during WAIT, WAIT_CYCLES=4
        xact(1, 5'h1F, 3'b101, 8'h11, 2, 0, rd, lat, acked);
        chk("abort_noack", 32'(acked), 32'd0);
        xact(1, 5'h1F, 3'b001, 8'h00, 0, 0, rd, lat, acked);
        chk("abort_rd_1F", 32'(rd), 32'h00);
        chk("w4_lat", 32'(lat), 32'd5);

        // Back-to-back zero-wait reads with REQ held high
        for (int i = 0; i < 4; i++)
            xact(2, 5'(i), 3'b101, 8'(8'hA0 + i), 0, 0, rd, lat, acked);
        for (int i = 0; i < 4; i++) begin
            xact(2, 5'(i), 3'b001, 8'h00, 0, (i < 3), rd, lat, acked);
            chk("b2b_rd", 32'(rd), 32'(8'hA0 + i));
            chk("b2b_lat", 32'(lat), 32'd1);
        end

        // Reset in the middle of a wait: pending write lost, RAM cleared
        xact(1, 5'h10, 3'b101, 8'hAA, 0, 0, rd, lat, acked);
        chk("pre_rst_echo", 32'(rd), 32'hAA);
        @(negedge clk);
        req[1] = 1'b1; addr[1] = 5'h11; cmd[1] = 3'b101; wdat[1] = 8'hBB;
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            chk("midrst_ack", 32'(ack_o[g]), 32'd0);
            chk("midrst_rd", 32'(rd_o[g]), 32'h00);
        end
        req[1] = 1'b0;
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        xact(1, 5'h10, 3'b001, 8'h00, 0, 0, rd, lat, acked);
        chk("post_rst_10", 32'(rd), 32'h00);
        xact(1, 5'h11, 3'b001, 8'h00, 0, 0, rd, lat, acked);
        chk("post_rst_11", 32'(rd), 32'h00);

        // Randomized traffic on every instance
        for (int g = 0; g < NI; g++) begin
            for (int n = 0; n < 60; n++) begin
                case ($urandom_range(0, 6))
                    0, 1, 2: rc = 3'b101;
                    3, 4, 5: rc = 3'b001;
                    default: begin
                        rc = 3'($urandom_range(0, 7));
                        if (rc[1:0] == 2'b01) rc[0] = 1'b0;
                    end
                endcase
                dp = 0;
                if (WC[g] > 0 && $urandom_range(0, 7) == 0) dp = $urandom_range(1, WC[g]);
                xact(g, 5'($urandom_range(0, 7)), rc, 8'($urandom), dp,
                     (dp == 0) && ($urandom_range(0, 3) == 0), rd, lat, acked);
                if (dp == 0) chk("rand_acked", 32'(acked), 32'd1);
            end
            req[g] = 1'b0;
            repeat (3) @(negedge clk);
        end

        // Many invalid commands: counter saturates
        for (int n = 0; n < 300; n++)
            xact(2, 5'($urandom_range(0, 31)), 3'b110, 8'($urandom), 0, 0, rd, lat, acked);
        chk("inv_many_rd", 32'(rd), 32'hFF);
`ifdef CV_SRAM_RSP_ERRCNT_EN
        chk("errcnt_sat", 32'(err_o[2]), 32'hFF);
`endif
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected end before %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cv_sram_rsp_32x8.md
# cv_sram_rsp_32x8

Target-side responder for the 40-bit split bus: a 32×8 register-file RAM on the RAM port of the 40-bit address decoder. It accepts one request at a time on the S_EX_REQ/S_EX_ACK handshake and performs byte writes or reads after a programmable number of wait states. It returns a single-cycle acknowledge with read data. It is the slave end of the same S_* protocol the decoder initiates on.

## Interface
- WAIT_CYCLES, 2, wait states between accept and acknowledge; legal range 0..15.
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- S_EX_REQ  in  1  request; held high by the initiator until ACK is seen.
- S_ADDR  in  5  byte address.
- S_CMD  in  3  command: [2] 1=write, 0=read; [1:0] must be 2'b01 (RAM class).
- S_D_WR  in  8  write data.
- S_EX_ACK  out  1  single-cycle acknowledge.
- S_D_RD  out  8  read data, valid while S_EX_ACK=1.
- ERR_CNT  out  8  invalid-command counter; present only with CV_SRAM_RSP_ERRCNT_EN.

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE → WAIT, or IDLE → ACK when WAIT_CYCLES=0, on S_EX_REQ=1.
  - S_ADDR, S_CMD and S_D_WR are latched at that edge.
  - The wait counter is loaded with WAIT_CYCLES−1.
- WAIT: the counter decrements each cycle.
  - At 0, go to ACK.
  - If S_EX_REQ drops, abort to IDLE: no write, no ACK, S_D_RD unchanged.
- ACK state drives S_EX_ACK=1 for exactly one cycle, then always returns to IDLE. No direct ACK→WAIT transition exists.
- Effects happen on the edge entering ACK:
  - Valid write (cmd[2]=1, cmd[1:0]=01): mem[addr] ← latched D_WR, and S_D_RD ← latched D_WR (echo).
  - Valid read: S_D_RD ← mem[addr].
  - Invalid command (cmd[1:0]≠01): no memory change; S_D_RD ← 8'hFF; still acknowledged.
- S_D_RD holds its last value outside ACK.
- Inputs are ignored outside IDLE. Later changes to address or data do not affect the latched request.
- Reset, any state, immediate:
  - S_EX_ACK=0, S_D_RD=8'h00, ERR_CNT=0.
  - FSM goes to IDLE, counter cleared, all 32 memory bytes cleared to 8'h00.
  - An in-flight transaction is lost and its write does not occur.

## Timing
- Accept edge N; S_EX_ACK high during cycle N+1+WAIT_CYCLES.
- Minimum transaction period is WAIT_CYCLES+2 cycles.
- REQ still high in the IDLE cycle after ACK is a new request and is accepted at that edge.
- Read-after-write to the same address in consecutive transactions returns the new data. There is no bypass hazard, because the write completes before IDLE.
- No combinational path from inputs to outputs; all outputs are registered.

## Configuration
- CV_SRAM_RSP_ERRCNT_EN
  - Defined: the ERR_CNT port exists. It increments by 1 on each invalid-command ACK edge and saturates at 8'hFF. Reset clears it to 0.
  - Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package cv_bus_pkg holds:
  - CMD_WR_BIT=2 and CMD_CLASS_RAM=2'b01.
  - The FSM state enum (IDLE/WAIT/ACK).
  - Bus widths (ADDR 5, DATA 8, CMD 3).
  - Invalid-read fill constant 8'hFF.
- One sub-module, cv_sram_32x8: async-reset register array with a synchronous write port and a combinational read port. The FSM, counter and optional ERR_CNT live in the top.

## Test plan
- Reset then idle: S_EX_ACK=0, S_D_RD=00, read of any address returns 00.
- WAIT_CYCLES=2 write addr 5'h0A data 8'h5C (CMD 3'b101), then read addr 0A (CMD 3'b001).
  - ACK occurs 3 cycles after each accept.
  - The write echoes 5C; the read returns 5C.
  - A read of 0B returns 00.
- Invalid CMD 3'b110 write of 8'h77 to addr 03.
  - Required: ACK given, S_D_RD=FF, and a subsequent read of 03 returns 00.
  - With the macro defined, ERR_CNT=1; after 300 invalid commands it is FF.
- REQ dropped during WAIT (WAIT_CYCLES=4, write 8'h11 to addr 1F, REQ low after 2 cycles).
  - Required: no ACK, and a subsequent read of 1F returns 00.
- Back-to-back with WAIT_CYCLES=0 and REQ held high across 4 reads of addrs 0..3.
  - ACK pulses every 2nd cycle with the correct data.
- RST_N asserted mid-WAIT after writes to 10/11: S_EX_ACK=0 immediately, the pending write is lost, and reads of 10/11 return 00.
